// File: rtl/seven_segment_sink.sv
// seven_segment_sink
//   Pin stage for the seven-segment display stream pair. An annode word and a
//   cathode word each arrive over their own stb/ack channel. Once one of each
//   has been accepted, all digits are blanked for BLANK_CYCLES clocks. Both
//   words are then driven onto the pads on the same edge, so the board never
//   shows ghosting or a half-updated digit.
//
// Parameters
//   DIGITS        annode pins driven, taken from input_annode[DIGITS-1:0] (<= 32)
//   SEGMENTS      cathode pins driven, taken from input_cathode[SEGMENTS-1:0] (<= 32)
//   BLANK_CYCLES  clocks all digits are held off before a new pair (0 = none)
//   ANNODE_OFF    annode pin level that turns a digit off
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   input_annode        annode word, with input_annode_stb / input_annode_ack
//   input_cathode       cathode word, with input_cathode_stb / input_cathode_ack
//   annode_pins         digit enables to the pads
//   cathode_pins        segment drives to the pads
//   busy                high while a complete pair is being blanked/applied
module seven_segment_sink #(
  parameter int   DIGITS       = 8,
  parameter int   SEGMENTS     = 8,
  parameter int   BLANK_CYCLES = 100,
  parameter logic ANNODE_OFF   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         input_annode,
  input  logic                input_annode_stb,
  output logic                input_annode_ack,
  input  logic [31:0]         input_cathode,
  input  logic                input_cathode_stb,
  output logic                input_cathode_ack,
  output logic [DIGITS-1:0]   annode_pins,
  output logic [SEGMENTS-1:0] cathode_pins,
  output logic                busy
);

  // The counter needs at least one bit even when blanking is disabled.
  localparam int CW   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         count;
  logic                  annode_pending;
  logic                  cathode_pending;
  logic [DIGITS-1:0]     annode_word;
  logic [SEGMENTS-1:0]   cathode_word;
  logic                  annode_xfer;
  logic                  cathode_xfer;
  logic                  unused_upper;

  assign annode_xfer  = input_annode_stb & input_annode_ack;
  assign cathode_xfer = input_cathode_stb & input_cathode_ack;
  assign busy         = (state == BLANK) || (state == APPLY);

  // The upper word bits carry nothing for this board and are dropped.
  assign unused_upper = ^{input_annode, input_cathode};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (annode_pending && cathode_pending) begin
          state_next = (BLANK_CYCLES == 0) ? APPLY : BLANK;
        end
      end
      BLANK: begin
        if (count == '0) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Loaded with BLANK_CYCLES-1 on entry, so BLANK lasts exactly BLANK_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (state == IDLE && state_next == BLANK) begin
      count <= CW'(LOAD);
    end else if (state == BLANK && count != '0) begin
      count <= count - CW'(1);
    end
  end

  // An ack is a one-cycle pulse. It is only offered in IDLE, and only while
  // that channel has nothing pending. A second word therefore waits on stb
  // until the current pair has been applied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_annode_ack  <= 1'b0;
      input_cathode_ack <= 1'b0;
    end else begin
      input_annode_ack  <= (state == IDLE) && !annode_pending &&
                           input_annode_stb && !input_annode_ack;
      input_cathode_ack <= (state == IDLE) && !cathode_pending &&
                           input_cathode_stb && !input_cathode_ack;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      annode_pending  <= 1'b0;
      cathode_pending <= 1'b0;
      annode_word     <= '0;
      cathode_word    <= '0;
    end else if (state == APPLY) begin
      annode_pending  <= 1'b0;
      cathode_pending <= 1'b0;
    end else begin
      if (annode_xfer) begin
        annode_pending <= 1'b1;
        annode_word    <= input_annode[DIGITS-1:0];
      end
      if (cathode_xfer) begin
        cathode_pending <= 1'b1;
        cathode_word    <= input_cathode[SEGMENTS-1:0];
      end
    end
  end

  // Digits go dark when blanking starts. Cathodes keep their old value until
  // APPLY, where both words land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      annode_pins  <= {DIGITS{ANNODE_OFF}};
      cathode_pins <= '1;
    end else if (state == APPLY) begin
      annode_pins  <= annode_word;
      cathode_pins <= cathode_word;
    end else if (state == IDLE && state_next == BLANK) begin
      annode_pins  <= {DIGITS{ANNODE_OFF}};
    end
  end

endmodule

// File: tb/tb_seven_segment_sink.sv
// tb_seven_segment_sink
//   Self-checking bench for seven_segment_sink. Instance dut uses
//   BLANK_CYCLES=4 and is tracked cycle by cycle by a scoreboard of
//   completed pairs. Instance dut0 uses BLANK_CYCLES=0 and covers the
//   no-blanking, simultaneous-handshake case.
module tb_seven_segment_sink;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] a_word = '0;
  logic        a_stb  = 1'b0;
  logic        a_ack;
  logic [31:0] c_word = '0;
  logic        c_stb  = 1'b0;
  logic        c_ack;
  logic [7:0]  ann_pins;
  logic [7:0]  cath_pins;
  logic        busy;

  logic [31:0] z_a_word = '0;
  logic        z_a_stb  = 1'b0;
  logic        z_a_ack;
  logic [31:0] z_c_word = '0;
  logic        z_c_stb  = 1'b0;
  logic        z_c_ack;
  logic [7:0]  z_ann;
  logic [7:0]  z_cath;
  logic        z_busy;

  seven_segment_sink #(.DIGITS(8), .SEGMENTS(8), .BLANK_CYCLES(B), .ANNODE_OFF(1'b1)) dut (
    .clk(clk), .rst(rst),
    .input_annode(a_word), .input_annode_stb(a_stb), .input_annode_ack(a_ack),
    .input_cathode(c_word), .input_cathode_stb(c_stb), .input_cathode_ack(c_ack),
    .annode_pins(ann_pins), .cathode_pins(cath_pins), .busy(busy)
  );

  seven_segment_sink #(.DIGITS(8), .SEGMENTS(8), .BLANK_CYCLES(0), .ANNODE_OFF(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .input_annode(z_a_word), .input_annode_stb(z_a_stb), .input_annode_ack(z_a_ack),
    .input_cathode(z_c_word), .input_cathode_stb(z_c_stb), .input_cathode_ack(z_c_ack),
    .annode_pins(z_ann), .cathode_pins(z_cath), .busy(z_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: a pair is pushed when its second word transfers. The pins
  // must show it B+2 edges later, with digits dark and busy high for the
  // B+1 cycles before that.
  typedef struct {
    logic [7:0] ann;
    logic [7:0] cath;
    int         due;
  } pair_t;

  pair_t      sb[$];
  logic [7:0] m_ann = 8'hFF;
  logic [7:0] m_cath = 8'hFF;
  logic [7:0] pa = '0;
  logic [7:0] pc = '0;
  logic       pend_a = 1'b0;
  logic       pend_c = 1'b0;
  logic       prev_a_ack = 1'b0;
  logic       prev_c_ack = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_ann = '0;
  logic [7:0] prev_cath = '0;

  always @(negedge clk) begin
    logic [7:0] exp_ann;
    logic       exp_busy;
    if (!rst) begin
      sb.delete();
      m_ann = 8'hFF;
      m_cath = 8'hFF;
      pend_a = 1'b0;
      pend_c = 1'b0;
      prev_a_ack = 1'b0;
      prev_c_ack = 1'b0;
      prev_valid = 1'b0;
    end else begin
      exp_ann = m_ann;
      exp_busy = 1'b0;
      if (sb.size() > 0) begin
        if (sb[0].due == cyc) begin
          m_ann = sb[0].ann;
          m_cath = sb[0].cath;
          exp_ann = m_ann;
          void'(sb.pop_front());
        end else if (cyc >= sb[0].due - B - 1) begin
          exp_ann = 8'hFF;
          exp_busy = 1'b1;
        end
      end
      check_output("sb_annode_pins", ann_pins, exp_ann);
      check_output("sb_cathode_pins", cath_pins, m_cath);
      check_output("sb_busy", busy, exp_busy);
      if (a_ack) check_output("annode_ack_pulse", prev_a_ack, 1'b0);
      if (c_ack) check_output("cathode_ack_pulse", prev_c_ack, 1'b0);
      if (prev_valid && cath_pins != prev_cath)
        check_output("no_ghost_annode_off", prev_ann, 8'hFF);
      if (a_stb && a_ack) begin
        pend_a = 1'b1;
        pa = a_word[7:0];
      end
      if (c_stb && c_ack) begin
        pend_c = 1'b1;
        pc = c_word[7:0];
      end
      if (pend_a && pend_c) begin
        sb.push_back('{ann: pa, cath: pc, due: cyc + 1 + B + 2});
        pend_a = 1'b0;
        pend_c = 1'b0;
      end
      prev_a_ack = a_ack;
      prev_c_ack = c_ack;
      prev_ann = ann_pins;
      prev_cath = cath_pins;
      prev_valid = 1'b1;
    end
  end

  task automatic send_annode(input logic [31:0] w);
    int n = 0;
    a_word = w;
    a_stb = 1'b1;
    do begin @(negedge clk); n++; end while (!a_ack && n < 200);
    if (!a_ack) check_output("annode_ack_timeout", 0, 1);
    @(posedge clk); #1;
    a_stb = 1'b0;
  endtask

  task automatic send_cathode(input logic [31:0] w);
    int n = 0;
    c_word = w;
    c_stb = 1'b1;
    do begin @(negedge clk); n++; end while (!c_ack && n < 200);
    if (!c_ack) check_output("cathode_ack_timeout", 0, 1);
    @(posedge clk); #1;
    c_stb = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    if (!(seen && !busy)) check_output("wait_idle_timeout", 0, 1);
  endtask

  typedef struct {
    logic [31:0] cath;
    logic [31:0] ann;
    logic [7:0]  exp_ann;
    logic [7:0]  exp_cath;
    bit          cath_first;
  } vec_t;

  task automatic apply_stimulus(input vec_t v);
    if (v.cath_first) begin
      send_cathode(v.cath);
      send_annode(v.ann);
    end else begin
      send_annode(v.ann);
      send_cathode(v.cath);
    end
    wait_idle();
  endtask

  initial begin
    vec_t vecs[5];
    int   nbusy;
    int   nff;
    int   n;

    vecs[0] = '{32'h000000C0, 32'h000000FE, 8'hFE, 8'hC0, 1'b1};
    vecs[1] = '{32'hFFFFFF92, 32'h123456FD, 8'hFD, 8'h92, 1'b0};
    vecs[2] = '{32'hA5A5A5F9, 32'h000000FB, 8'hFB, 8'hF9, 1'b1};
    vecs[3] = '{32'h00000000, 32'hFFFFFF00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{32'h000000A4, 32'h0000007F, 8'h7F, 8'hA4, 1'b1};

    // Reset held with both strobes up: pins off, no acks.
    a_stb = 1'b1; a_word = 32'h11;
    c_stb = 1'b1; c_word = 32'h22;
    z_a_stb = 1'b1; z_c_stb = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_annode_pins", ann_pins, 8'hFF);
    check_output("reset_cathode_pins", cath_pins, 8'hFF);
    check_output("reset_acks", {a_ack, c_ack, z_a_ack, z_c_ack}, 4'b0000);
    check_output("reset_busy", {busy, z_busy}, 2'b00);
    @(posedge clk); #1;
    a_stb = 1'b0; c_stb = 1'b0; z_a_stb = 1'b0; z_c_stb = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post_reset_idle", {busy, a_ack, c_ack}, 3'b000);
    @(posedge clk); #1;

    // Directed pairs in both orders, upper bits ignored.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_annode_pins", i), ann_pins, vecs[i].exp_ann);
      check_output($sformatf("vec%0d_cathode_pins", i), cath_pins, vecs[i].exp_cath);
      @(posedge clk); #1;
    end

    // Blank window length: annodes dark and busy for B+1 cycles, then both apply.
    $display("[TB] blank window");
    send_cathode(32'h000000C0);
    send_annode(32'h000000FE);
    nbusy = 0; nff = 0; n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (busy) begin
        nbusy++;
        if (ann_pins == 8'hFF) nff++;
      end else if (nbusy > 0) break;
    end
    check_output("blank_busy_cycles", nbusy, B + 1);
    check_output("blank_annode_off_cycles", nff, B + 1);
    check_output("blank_apply_annode", ann_pins, 8'hFE);
    check_output("blank_apply_cathode", cath_pins, 8'hC0);
    @(posedge clk); #1;

    // Second annode held while first is pending: no ack until the pair applies.
    $display("[TB] backpressure");
    send_annode(32'h000000F1);
    a_word = 32'h000000F2;
    a_stb = 1'b1;
    nff = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack) nff++;
    end
    check_output("held_annode_not_acked", nff, 0);
    @(posedge clk); #1;
    send_cathode(32'h00000031);
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ack && n < 40);
    check_output("held_ack_after_apply", a_ack, 1'b1);
    check_output("held_first_pair_annode", ann_pins, 8'hF1);
    check_output("held_first_pair_cathode", cath_pins, 8'h31);
    @(posedge clk); #1;
    a_stb = 1'b0;
    send_cathode(32'h00000032);
    wait_idle();
    check_output("held_second_pair_annode", ann_pins, 8'hF2);
    check_output("held_second_pair_cathode", cath_pins, 8'h32);
    @(posedge clk); #1;

    // Reset in the middle of blanking drops the pending pair.
    $display("[TB] reset during blank");
    send_cathode(32'h00000012);
    send_annode(32'h0000007F);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("midblank_reset_annode", ann_pins, 8'hFF);
    check_output("midblank_reset_cathode", cath_pins, 8'hFF);
    check_output("midblank_reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_output("midblank_never_applied", {ann_pins, cath_pins}, 16'hFFFF);
    @(posedge clk); #1;

    // No-blank instance: both strobes together, both acked together, pins 2 edges later.
    $display("[TB] zero blank simultaneous");
    z_a_word = 32'hFFFFFFF7; z_c_word = 32'h00000099;
    z_a_stb = 1'b1; z_c_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(z_a_ack || z_c_ack) && n < 10);
    check_output("zero_both_acked", {z_a_ack, z_c_ack}, 2'b11);
    @(posedge clk); #1;
    z_a_stb = 1'b0; z_c_stb = 1'b0;
    @(negedge clk);
    check_output("zero_edge1_pins", {z_ann, z_cath, z_busy}, 17'h1FFFE);
    @(negedge clk);
    check_output("zero_edge2_apply", {z_ann, z_cath, z_busy}, 17'h1FFFF);
    @(negedge clk);
    check_output("zero_edge3_pins", {z_ann, z_cath, z_busy}, {8'hF7, 8'h99, 1'b0});
    @(posedge clk); #1;

    // Random strobe timing on both channels, tracked by the scoreboard.
    $display("[TB] random pairs");
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send_annode($urandom);
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send_cathode($urandom);
        end
      end
    join
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("random_drained", sb.size(), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
